// File: rtl/grasspopper_arbiter.sv
// grasspopper_arbiter: round-robin front end that time-shares a single
// grasspopper cipher core between NREQ requesters. One block is in flight at
// a time; a watchdog resets the core and returns an error if it hangs.
module grasspopper_arbiter #(
    parameter int NREQ    = 4,     // number of requesters, 2..8
    parameter int TIMEOUT = 1024,  // max cycles in WAIT before the core is reset
    parameter int TW      = 11     // timer width, >= clog2(TIMEOUT)+1
) (
    input  logic                 pclk_i,
    input  logic                 presetn_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*128-1:0]  req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [127:0]         rsp_data_o,
    output logic                 rsp_err_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [127:0]         core_data_o,
    output logic                 core_req_o,
    output logic                 core_ack_o,
    output logic                 core_rst_o,
    input  logic [127:0]         core_data_i,
    input  logic                 core_valid_i,
    input  logic                 core_busy_i,
    output logic                 busy_o,
    output logic [2:0]           owner_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [2:0]      ptr_q;        // round-robin search start
    logic [2:0]      owner_q;      // requester that owns the current block
    logic [TW-1:0]   timer_q;      // cycles spent waiting for the core
    logic [127:0]    blk_q;        // block being encrypted
    logic [127:0]    rsp_data_q;   // result returned to the owner
    logic            rsp_err_q;

    logic [NREQ-1:0] rot_valid;    // req_valid_i rotated so bit 0 is ptr_q
    logic [NREQ-1:0] owner_oh;
    logic [2:0]      win;
    logic            grant_ok;
    logic            owner_ready;
    logic            timeout;

    assign rot_valid   = NREQ'({req_valid_i, req_valid_i} >> ptr_q);
    assign owner_oh    = NREQ'(1) << owner_q;
    assign owner_ready = |(rsp_ready_i & owner_oh);
    assign grant_ok    = (|req_valid_i) & ~core_busy_i;
    assign timeout     = (timer_q == TW'(TIMEOUT - 1));

    // Pick the first valid requester at or after ptr_q, wrapping modulo NREQ.
    always_comb begin
        win = '0;
        // Scan from the far end down so the nearest valid requester is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                win = 3'((int'(ptr_q) + k >= NREQ) ? int'(ptr_q) + k - NREQ
                                                   : int'(ptr_q) + k);
            end
        end
    end

    // Next-state and pulse outputs of the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // of the case below can leave one unassigned and infer a latch.
        state_d     = state_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        core_req_o  = 1'b0;
        core_ack_o  = 1'b0;
        core_rst_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    req_ready_o = NREQ'(1) << win;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                core_req_o = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                // A result arriving on the last allowed cycle still wins over the watchdog.
                if (core_valid_i) begin
                    core_ack_o = 1'b1;
                    state_d    = RESP;
                end else if (timeout) begin
                    core_rst_o = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = owner_oh;
                if (owner_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, timer and data registers.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            timer_q    <= '0;
            // NOTE: the 128-bit data registers are reset too, so core_data_o
            // and rsp_data_o read zero straight out of reset.
            blk_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here sample
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (grant_ok) begin
                        blk_q   <= req_data_i[int'(win)*128 +: 128];
                        owner_q <= win;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                end
                WAIT: begin
                    if (core_valid_i) begin
                        rsp_data_q <= core_data_i;
                        rsp_err_q  <= 1'b0;
                    end else if (timeout) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RESP: begin
                    if (owner_ready) begin
                        ptr_q <= (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_data_o = blk_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_grasspopper_arbiter.sv
// Bench for grasspopper_arbiter: a transaction-level model (grant timestamp,
// result timestamp, pending response) predicts every output each cycle, and
// directed scenarios pin the model with hand-computed literal expectations.
module tb_grasspopper_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int TW      = 5;

    logic                pclk_i;
    logic                presetn_i;
    logic [NREQ-1:0]     req_valid_i;
    logic [NREQ*128-1:0] req_data_i;
    logic [NREQ-1:0]     req_ready_o;
    logic [NREQ-1:0]     rsp_valid_o;
    logic [127:0]        rsp_data_o;
    logic                rsp_err_o;
    logic [NREQ-1:0]     rsp_ready_i;
    logic [127:0]        core_data_o;
    logic                core_req_o;
    logic                core_ack_o;
    logic                core_rst_o;
    logic [127:0]        core_data_i;
    logic                core_valid_i;
    logic                core_busy_i;
    logic                busy_o;
    logic [2:0]          owner_o;

    grasspopper_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .pclk_i       (pclk_i),
        .presetn_i    (presetn_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_ready_i  (rsp_ready_i),
        .core_data_o  (core_data_o),
        .core_req_o   (core_req_o),
        .core_ack_o   (core_ack_o),
        .core_rst_o   (core_rst_o),
        .core_data_i  (core_data_i),
        .core_valid_i (core_valid_i),
        .core_busy_i  (core_busy_i),
        .busy_o       (busy_o),
        .owner_o      (owner_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    // Core model: raises valid core_delay cycles after core_req (never if < 1).
    int           core_delay = -1;
    bit           cm_pend    = 0;
    int           cm_at      = 0;
    logic         cv_nxt     = 1'b0;
    logic [127:0] cd_nxt     = '0;

    // Transaction-level arbiter model.
    bit           m_active = 0;
    bit           m_done   = 0;
    int           m_ptr    = 0;
    int           m_owner  = 0;
    int           m_acc    = 0;
    logic [127:0] m_blk    = '0;
    logic [127:0] m_rsp    = '0;
    logic         m_err    = 1'b0;

    int grant_who[$];
    int grant_cyc[$];
    int req_cyc[$];
    int ack_cyc[$];
    int rst_cyc[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial begin
        pclk_i = 1'b0;
        forever #5 pclk_i = ~pclk_i;
    end

    // Apply core model outputs just after each rising edge.
    initial begin
        core_valid_i = 1'b0;
        core_data_i  = '0;
        forever begin
            @(posedge pclk_i);
            #1;
            core_valid_i = cv_nxt;
            core_data_i  = cd_nxt;
        end
    end

    // Compare process: predicts all outputs for the current cycle from the model.
    initial begin : monitor
        logic [NREQ-1:0] e_rdy;
        logic [NREQ-1:0] e_rv;
        logic            e_req, e_ack, e_rst, e_busy, chk_rsp;
        logic [127:0]    e_cdata;
        int              e_owner, w, j;
        forever begin
            @(negedge pclk_i);
            if (mon_en) begin
                if (!presetn_i) begin
                    check("rst_req_ready", req_ready_o, '0);
                    check("rst_rsp_valid", rsp_valid_o, '0);
                    check("rst_rsp_data", rsp_data_o, '0);
                    check("rst_rsp_err", rsp_err_o, 0);
                    check("rst_core_data", core_data_o, '0);
                    check("rst_core_req", core_req_o, 0);
                    check("rst_core_ack", core_ack_o, 0);
                    check("rst_core_rst", core_rst_o, 0);
                    check("rst_busy", busy_o, 0);
                    check("rst_owner", owner_o, 0);
                    m_active = 0; m_done = 0; m_ptr = 0; m_owner = 0;
                    m_blk = '0; m_rsp = '0; m_err = 1'b0;
                end else begin
                    e_busy  = m_active;
                    e_owner = m_owner;
                    e_cdata = m_blk;
                    e_rdy   = '0;
                    e_rv    = '0;
                    e_req   = 1'b0;
                    e_ack   = 1'b0;
                    e_rst   = 1'b0;
                    chk_rsp = 1'b0;
                    if (!m_active) begin
                        w = -1;
                        if (!core_busy_i) begin
                            for (int i = 0; i < NREQ; i++) begin
                                j = (m_ptr + i) % NREQ;
                                if (w < 0 && req_valid_i[j]) w = j;
                            end
                        end
                        if (w >= 0) begin
                            e_rdy[w] = 1'b1;
                            m_active = 1; m_done = 0; m_acc = cyc; m_owner = w;
                            m_blk    = req_data_i[w*128 +: 128];
                        end
                    end else if (cyc == m_acc + 1) begin
                        e_req = 1'b1;
                    end else if (!m_done) begin
                        if (core_valid_i) begin
                            e_ack = 1'b1; m_done = 1; m_rsp = core_data_i; m_err = 1'b0;
                        end else if (cyc - m_acc - 2 == TIMEOUT - 1) begin
                            e_rst = 1'b1; m_done = 1; m_rsp = '0; m_err = 1'b1;
                        end
                    end else begin
                        e_rv[m_owner] = 1'b1;
                        chk_rsp       = 1'b1;
                        if (rsp_ready_i[m_owner]) begin
                            m_active = 0; m_done = 0; m_ptr = (m_owner + 1) % NREQ;
                        end
                    end
                    check("req_ready", req_ready_o, e_rdy);
                    check("rsp_valid", rsp_valid_o, e_rv);
                    check("core_req", core_req_o, e_req);
                    check("core_ack", core_ack_o, e_ack);
                    check("core_rst", core_rst_o, e_rst);
                    check("busy", busy_o, e_busy);
                    check("owner", owner_o, e_owner);
                    check("core_data", core_data_o, e_cdata);
                    if (chk_rsp) begin
                        check("rsp_data", rsp_data_o, m_rsp);
                        check("rsp_err", rsp_err_o, m_err);
                    end
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready_o[i]) begin
                        grant_who.push_back(i);
                        grant_cyc.push_back(cyc);
                    end
                end
                if (core_req_o) req_cyc.push_back(cyc);
                if (core_ack_o) ack_cyc.push_back(cyc);
                if (core_rst_o) rst_cyc.push_back(cyc);
            end
            // Core model decides its valid/data for the next cycle.
            if (!presetn_i || core_rst_o) begin
                cm_pend = 0;
            end else begin
                if (core_ack_o && core_valid_i) cm_pend = 0;
                if (core_req_o && core_delay >= 1) begin
                    cm_pend = 1;
                    cm_at   = cyc + core_delay;
                    cd_nxt  = ~core_data_o;
                end
            end
            cv_nxt = cm_pend && (cyc + 1 >= cm_at);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pclk_i);
            #1;
        end
    endtask

    task automatic wait_grant(input int maxc, output int who);
        int n0 = grant_who.size();
        bit seen = 0;
        who = -1;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge pclk_i);
            #1;
            if (grant_who.size() > n0) begin
                seen = 1;
                who  = grant_who[n0];
            end
        end
        check("grant_seen", seen, 1);
    endtask

    task automatic wait_rsp(input int idx, input int maxc);
        bit seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge pclk_i);
            #1;
            if (rsp_valid_o[idx]) seen = 1;
        end
        check("rsp_seen", seen, 1);
    endtask

    task automatic wait_idle(input int maxc);
        bit seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge pclk_i);
            #1;
            if (!busy_o) seen = 1;
        end
        check("idle_seen", seen, 1);
    endtask

    task automatic handshake(input logic [NREQ-1:0] mask);
        step(1);
        rsp_ready_i = mask;
        step(1);
        rsp_ready_i = '0;
    endtask

    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin : stimulus
        int who, n0, a0, r0;
        presetn_i   = 1'b1;
        req_valid_i = '0;
        rsp_ready_i = '0;
        core_busy_i = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data_i[i*128 +: 128] = {4{32'hC0DE0000 | i}};
        #2;
        presetn_i = 1'b0;
        mon_en    = 1;
        step(3);
        presetn_i = 1'b1;
        step(2);

        // All requesters held for 8 transactions, response taken at once.
        core_delay  = 2;
        rsp_ready_i = '1;
        req_valid_i = '1;
        n0 = grant_who.size();
        for (int k = 0; k < 8; k++) wait_grant(20, who);
        step(1);
        req_valid_i = '0;
        wait_idle(20);
        rsp_ready_i = '0;
        for (int k = 0; k < 8; k++) check("t2_order", grant_who[n0 + k], exp_order[k]);
        check("t2_spacing", grant_cyc[n0 + 1] - grant_cyc[n0], 5);

        // Single request on 0, core answers 5 cycles after core_req.
        req_data_i[0 +: 128] = 128'h11223344556677889900AABBCCDDEEFF;
        core_delay = 5;
        a0 = ack_cyc.size();
        step(1);
        req_valid_i = 4'b0001;
        wait_grant(10, who);
        check("t1_winner", who, 0);
        step(1);
        req_valid_i = '0;
        wait_rsp(0, 30);
        check("t1_req_latency", req_cyc[$] - grant_cyc[$], 1);
        check("t1_ack_delay", ack_cyc[$] - req_cyc[$], 5);
        check("t1_ack_count", ack_cyc.size() - a0, 1);
        check("t1_rsp_valid", rsp_valid_o, 4'b0001);
        check("t1_rsp_data", rsp_data_o, 128'hEEDDCCBBAA99887766FF554433221100);
        check("t1_rsp_err", rsp_err_o, 0);
        handshake(4'b0001);

        // Core never answers: watchdog fires 16 cycles after core_req.
        core_delay = -1;
        a0 = ack_cyc.size();
        r0 = rst_cyc.size();
        step(1);
        req_valid_i = 4'b0010;
        wait_grant(10, who);
        check("t3_winner", who, 1);
        step(1);
        req_valid_i = '0;
        wait_rsp(1, 40);
        check("t3_rst_count", rst_cyc.size() - r0, 1);
        check("t3_rst_delay", rst_cyc[$] - req_cyc[$], 16);
        check("t3_ack_count", ack_cyc.size() - a0, 0);
        check("t3_rsp_err", rsp_err_o, 1);
        check("t3_rsp_data", rsp_data_o, '0);
        handshake(4'b0010);

        // Result arrives on the watchdog's last cycle: result wins.
        core_delay = 16;
        a0 = ack_cyc.size();
        r0 = rst_cyc.size();
        step(1);
        req_valid_i = 4'b0010;
        wait_grant(10, who);
        step(1);
        req_valid_i = '0;
        wait_rsp(1, 40);
        check("t4_ack_delay", ack_cyc[$] - req_cyc[$], 16);
        check("t4_rst_count", rst_cyc.size() - r0, 0);
        check("t4_rsp_err", rsp_err_o, 0);
        check("t4_rsp_data", rsp_data_o, 128'h3F21FFFE3F21FFFE3F21FFFE3F21FFFE);
        handshake(4'b0010);

        // Owner 2 holds off its response while 3 waits with rsp_ready high.
        core_delay = 3;
        step(1);
        rsp_ready_i = 4'b1000;
        req_valid_i = 4'b1100;
        wait_grant(10, who);
        check("t5_winner", who, 2);
        step(1);
        req_valid_i = 4'b1000;
        wait_rsp(2, 30);
        n0 = grant_who.size();
        for (int k = 0; k < 10; k++) begin
            check("t5_rsp_owner", rsp_valid_o, 4'b0100);
            check("t5_rsp_hold", rsp_data_o, 128'h3F21FFFD3F21FFFD3F21FFFD3F21FFFD);
            @(negedge pclk_i);
            #1;
        end
        check("t5_no_grant", grant_who.size() - n0, 0);
        step(1);
        rsp_ready_i = 4'b1100;
        step(1);
        rsp_ready_i = 4'b1000;
        wait_grant(10, who);
        check("t5_next", who, 3);
        step(1);
        req_valid_i = '0;
        wait_idle(30);
        rsp_ready_i = '0;

        // Move the pointer to 2, then block grants with core_busy_i.
        core_delay  = 2;
        step(1);
        rsp_ready_i = 4'b0010;
        req_valid_i = 4'b0010;
        wait_grant(10, who);
        check("t6_pre_winner", who, 1);
        step(1);
        req_valid_i = '0;
        wait_idle(20);
        rsp_ready_i = '0;
        core_delay  = -1;
        step(1);
        core_busy_i = 1'b1;
        req_valid_i = 4'b1000;
        n0 = grant_who.size();
        step(5);
        check("t6_busy_no_grant", grant_who.size() - n0, 0);
        core_busy_i = 1'b0;
        wait_grant(10, who);
        check("t6_busy_release", who, 3);
        step(1);
        req_valid_i = '0;
        step(5);
        check("t6_in_wait", busy_o, 1);
        check("t6_owner", owner_o, 3);
        presetn_i = 1'b0;
        #1;
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_owner", owner_o, 0);
        check("t6_rst_core_data", core_data_o, '0);
        step(2);
        presetn_i   = 1'b1;
        core_delay  = 2;
        step(1);
        rsp_ready_i = '1;
        req_valid_i = '1;
        wait_grant(10, who);
        check("t6_ptr_after_reset", who, 0);
        step(1);
        req_valid_i = '0;
        wait_idle(20);
        rsp_ready_i = '0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
